counter_up_down: RTL and testbench

//   Free-running binary up/down counter with a single direction-select input.

---
 rtl/counter_up_down.sv | 24 ++
 tb/tb_counter_up_down.sv | 97 +++++++++
 2 files changed

// File: rtl/counter_up_down.sv
// counter_up_down: free-running modulo-2**WIDTH up/down counter with terminal flags and registered wrap pulse
module counter_up_down #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= mode ? count + WIDTH'(1) : count - WIDTH'(1);
            wrap  <= mode ? &count : ~|count;
        end
    end
    assign at_max = &count;
    assign at_min = ~|count;
endmodule

// File: tb/tb_counter_up_down.sv
// tb_counter_up_down: checks 4- and 8-bit counters against an arithmetic reference model
module tb_counter_up_down;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode  = 1'b1;
    logic [3:0] count4;
    logic [7:0] count8;
    logic       at_max4, at_min4, wrap4, at_max8, at_min8, wrap8;
    int         total = 0;
    int         bad = 0;
    int         m4 = 0, m8 = 0;
    int         w4 = 0, w8 = 0;

    counter_up_down #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .mode(mode),
        .count(count4), .at_max(at_max4), .at_min(at_min4), .wrap(wrap4)
    );
    counter_up_down #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .mode(mode),
        .count(count8), .at_max(at_max8), .at_min(at_min8), .wrap(wrap8)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: next value is plain modular arithmetic; a wrap is a step leaving a terminal value outward.
    function automatic void model(input bit r, input bit m, input int modulus, inout int c, inout int w);
        if (!r) begin
            c = 0;
            w = 0;
        end else begin
            w = (m && c == modulus - 1) || (!m && c == 0);
            c = m ? (c + 1) % modulus : (c + modulus - 1) % modulus;
        end
    endfunction

    task automatic step(input bit r, input bit m);
        @(negedge clock);
        reset = r;
        mode  = m;
        @(posedge clock);
        model(r, m, 16, m4, w4);
        model(r, m, 256, m8, w8);
        #1;
        chk("count4", 32'(count4), 32'(m4));
        chk("at_max4", 32'(at_max4), 32'(m4 == 15));
        chk("at_min4", 32'(at_min4), 32'(m4 == 0));
        chk("wrap4", 32'(wrap4), 32'(w4));
        chk("count8", 32'(count8), 32'(m8));
        chk("at_max8", 32'(at_max8), 32'(m8 == 255));
        chk("at_min8", 32'(at_min8), 32'(m8 == 0));
        chk("wrap8", 32'(wrap8), 32'(w8));
    endtask

    initial begin
        step(0, 1);
        step(0, 1);
        chk("rst_count", 32'(count4), 32'd0);
        chk("rst_at_min", 32'(at_min4), 32'd1);
        chk("rst_wrap", 32'(wrap4), 32'd0);
        for (int i = 0; i < 16; i++) step(1, 1);
        chk("up_wrap_count", 32'(count4), 32'd0);
        chk("up_wrap_pulse", 32'(wrap4), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 1);
        for (int i = 0; i < 7; i++) step(1, 0);
        chk("down_seq_end", 32'(count4), 32'd14);
        step(1, 1);
        step(1, 0);
        chk("max_reverse", 32'(count4), 32'd14);
        for (int i = 0; i < 14; i++) step(1, 0);
        step(1, 1);
        chk("min_reverse", 32'(count4), 32'd1);
        chk("min_reverse_wrap", 32'(wrap4), 32'd0);
        for (int i = 0; i < 40 && count4 != 4'd9; i++) step(1, 1);
        chk("reach9", 32'(count4), 32'd9);
        step(0, 1);
        chk("midreset", 32'(count4), 32'd0);
        step(1, 1);
        chk("resume", 32'(count4), 32'd1);
        step(1, 1);
        step(1, 1);
        for (int i = 0; i < 4; i++) step(1, i % 2 == 0);
        chk("toggle_end", 32'(count4), 32'd3);
        for (int i = 0; i < 300; i++) step(1, 1);
        for (int i = 0; i < 300; i++) step(1, 0);
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 19) != 0, 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
